// File: rtl/rpc2_ctrl_sync_fifo_prog_pkg.sv
// Shared constants and helpers for the RPC2 controller sync FIFO.
package rpc2_ctrl_fifo_pkg;

  typedef enum logic {
    FIFO_MODE_REG  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO (DEPTH) is representable.
  function automatic int unsigned count_width(input int unsigned addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

// File: rtl/rpc2_ctrl_sync_fifo_prog_if.sv
// Handshake bundle for rpc2_ctrl_sync_fifo_prog; error signals exist only with RPC2_CTRL_FIFO_ERR_EN.
interface rpc2_ctrl_sync_fifo_prog_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_BITS  = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_BITS:0]    count;
  logic [ADDR_BITS:0]    af_thresh;
  logic [ADDR_BITS:0]    ae_thresh;
`ifdef RPC2_CTRL_FIFO_ERR_EN
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty, count,
           overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty, count,
           overflow, underflow
  );
`else
  modport master (
    output wr_en, wr_data, rd_en, af_thresh, ae_thresh,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty, count
  );
  modport slave (
    input  wr_en, wr_data, rd_en, af_thresh, ae_thresh,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty, count
  );
`endif
endinterface

// File: rtl/rpc2_ctrl_sync_fifo_prog_ram.sv
// FIFO storage: one write port, one read port; registered read (REG) or asynchronous read (FWFT).
module rpc2_ctrl_fifo_ram
  import rpc2_ctrl_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FWFT       = int'(FIFO_MODE_REG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_async_rd
    assign rdata = mem[raddr];
  end else begin : g_sync_rd
    always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rpc2_ctrl_sync_fifo_prog.sv
// Single-clock programmable FIFO: count, AF/AE thresholds, REG/FWFT read.
// Optional sticky overflow/underflow flags with macro RPC2_CTRL_FIFO_ERR_EN.
module rpc2_ctrl_sync_fifo_prog
  import rpc2_ctrl_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_BITS  = 3,
  parameter int unsigned FWFT       = int'(FIFO_MODE_REG)
) (
  input logic clk,
  input logic rst,
  rpc2_ctrl_sync_fifo_prog_if.slave fif
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CW    = count_width(ADDR_BITS);
  typedef logic [CW-1:0] count_t;
  localparam count_t DEPTH_C = count_t'(DEPTH);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  count_t               count_q;
  logic                 full_w;
  logic                 empty_w;
  logic                 wr_acc;
  logic                 rd_acc;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  assign wr_acc  = fif.wr_en && !full_w;
  assign rd_acc  = fif.rd_en && !empty_w;

  assign fif.full         = full_w;
  assign fif.empty        = empty_w;
  assign fif.almost_full  = (count_q >= fif.af_thresh);
  assign fif.almost_empty = (count_q <= fif.ae_thresh);
  assign fif.count        = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count_q <= count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_q <= count_q - 1'b1;
    end
  end

  rpc2_ctrl_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .FWFT       (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr),
    .wdata (fif.wr_data),
    .re    (rd_acc && !rst),
    .raddr (rd_ptr),
    .rdata (fif.rd_data)
  );

  if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft_valid
    assign fif.rd_valid = !empty_w;
  end else begin : g_reg_valid
    logic rd_valid_q;
    always_ff @(posedge clk) begin
      if (rst) rd_valid_q <= 1'b0;
      else     rd_valid_q <= rd_acc;
    end
    assign fif.rd_valid = rd_valid_q;
  end

`ifdef RPC2_CTRL_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Set takes priority over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (fif.wr_en && full_w)  overflow_q  <= 1'b1;
      else if (fif.err_clr)     overflow_q  <= 1'b0;
      if (fif.rd_en && empty_w) underflow_q <= 1'b1;
      else if (fif.err_clr)     underflow_q <= 1'b0;
    end
  end

  assign fif.overflow  = overflow_q;
  assign fif.underflow = underflow_q;
`endif

endmodule

// File: doc/rpc2_ctrl_sync_fifo_prog.md
# rpc2_ctrl_sync_fifo_prog

Single-clock, parametrised FIFO for the RPC2 controller. It replaces ad-hoc sync FIFO instances on the AXI-side command, write-data and read-data paths. Added over the previous generation:
- occupancy count output
- programmable almost-full / almost-empty thresholds
- selectable read mode: registered read or first-word-fall-through (FWFT)
- optional sticky overflow/underflow error flags

It sits between the AXI slave front-end and the memory-side sequencer, entirely in the `clk` domain.

## Interface
Reset is synchronous and active-high; there is one clock.

Parameters:
- `DATA_WIDTH`, default 16: word width in bits, 1..256.
- `ADDR_BITS`, default 3: depth is `DEPTH = 1<<ADDR_BITS`, 1..10.
- `FWFT`, default 0: 0 = registered read, 1 = first-word-fall-through.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `wr_en`  in  1  write request.
- `wr_data`  in  DATA_WIDTH  write word.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count >= `af_thresh`.
- `rd_en`  in  1  read/pop request.
- `rd_data`  out  DATA_WIDTH  read word.
- `rd_valid`  out  1  `rd_data` holds a word (see Operation).
- `empty`  out  1  count == 0.
- `almost_empty`  out  1  count <= `ae_thresh`.
- `count`  out  ADDR_BITS+1  current occupancy, 0..DEPTH.
- `af_thresh`  in  ADDR_BITS+1  almost-full threshold, quasi-static.
- `ae_thresh`  in  ADDR_BITS+1  almost-empty threshold, quasi-static.
- `err_clr`  in  1  clears the sticky error flags (only present with the macro).
- `overflow`  out  1  sticky: a write was attempted while full (only present with the macro).
- `underflow`  out  1  sticky: a read was attempted while empty (only present with the macro).

## Operation
- A write is accepted when `wr_en && !full`. Accepted data is stored at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- A read is accepted when `rd_en && !empty`. `rd_ptr` increments modulo DEPTH.
- Pointers are ADDR_BITS wide and wrap naturally. `count` is a separate ADDR_BITS+1 register:
  - +1 on write only
  - −1 on read only
  - unchanged on both or neither.
- Simultaneous read and write:
  - When full: the read is accepted and the write is rejected (no pass-through). `count` becomes DEPTH−1.
  - When empty: the write is accepted and the read is rejected (no bypass). `count` becomes 1.
  - Otherwise both are accepted and `count` is unchanged.
- `full`, `empty`, `almost_full` and `almost_empty` are combinational decodes of the registered `count`, with no other logic in the path.
- FWFT=0: on an accepted read, `rd_data` is loaded with `mem[rd_ptr]` and `rd_valid` pulses for one cycle. When no read is accepted, `rd_data` holds its last value.
- FWFT=1: `rd_data = mem[rd_ptr]`, read combinationally, and `rd_valid = !empty`. `rd_en` acts as a pop acknowledge.
- Rejected requests change no state.

## Timing
- Reset values:
  - `count`=0, `empty`=1, `full`=0, `almost_full`=(`af_thresh`==0), `almost_empty`=1
  - `rd_valid`=0, `rd_data`=0, pointers=0
  - `overflow`=0, `underflow`=0
- Reset asserted mid-operation discards all contents at the next edge. Writes and reads presented in the same cycle as `rst` are ignored.
- Flags update one cycle after the accepted operation.
- Write-to-read latency on an empty FIFO:
  - FWFT=1: the word is visible on `rd_data` with `rd_valid`=1 in the cycle after the write.
  - FWFT=0: data appears one cycle after the accepted `rd_en`.
- Back-to-back operation: one write and one read per cycle sustained; no bubbles.

## Configuration
- Macro `RPC2_CTRL_FIFO_ERR_EN`.
- Defined: `overflow` sets on `wr_en && full`, and `underflow` sets on `rd_en && empty`. Both flags hold until `err_clr` or `rst`. If a set condition and `err_clr` occur in the same cycle, set wins.
- Undefined: the `err_clr`, `overflow` and `underflow` ports and their logic are absent, and over/underflow attempts are silently ignored.

## Structure
- Package `rpc2_ctrl_fifo_pkg` holds:
  - the read-mode constants `FIFO_MODE_REG=0` and `FIFO_MODE_FWFT=1`
  - a `clog2` function
  - the count-width typedef helper.
- Sub-module `rpc2_ctrl_fifo_ram`: DEPTH×DATA_WIDTH array with one write port and one read port. Read is registered when FWFT=0 and asynchronous when FWFT=1. It is kept separate so a DPRAM macro can replace it.
- Pointer, count and flag logic lives in the top module.

## Test plan
- Fill/drain, DEPTH=8: write 0x0001..0x0008 → `full`=1 and `count`=8. Then 8 reads → data 0x0001..0x0008 in order, `empty`=1.
- Thresholds: `af_thresh`=6, `ae_thresh`=2. Write 6 words → `almost_full` asserts the cycle after the 6th write. Read 4 words → `almost_empty` asserts at `count`=2.
- Simultaneous ops:
  - full + `rd_en` + `wr_en` → `count`=7, the written word is dropped.
  - empty + both → `count`=1, `rd_valid` stays 0.
  - mid-level (`count`=4) + both → `count` stays 4.
- Wrap-around: 20 interleaved write/read pairs with incrementing data → no data loss across the pointer wrap, and `count` never exceeds 8.
- FWFT=1: single write of 0xA5A5 to an empty FIFO → next cycle `rd_data`=0xA5A5 and `rd_valid`=1. `rd_en` → `empty`=1 on the following cycle.
- Errors (macro defined): `wr_en` while full → `overflow`=1, sticky. `err_clr` → 0. Reset during a partially full state → `count`=0, `empty`=1, `overflow`=0.
